alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Sequencer that produces the 2-bit `state` bus consumed by the LED alarm display.
- Tracks a sensor trigger and an operator acknowledge button.
- Escalates NORMAL -> ATTENTION -> EMERGENCY on timeouts; supports a timed SILENCED period.
- Exports a seconds countdown for the 7-segment display and a saturating emergency-event counter.

Parameters:
- TICKS_PER_SEC, 50000000: clk cycles per one-second tick (range 2..2^26).
- ATTENTION_SECS, 10: seconds in ATTENTION without ack before escalating (1..255).
- SILENCE_SECS, 30: seconds spent in SILENCED after an ack (1..255).
- CLEAR_SECS, 5: continuous trigger-low seconds for auto-clear (1..255; used only with ALARM_AUTO_CLEAR_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- trigger  in  1  sensor alarm request, level, already synchronous to clk
- ack  in  1  acknowledge button, level; rising edge detected internally
- state  out  2  `STATE_NORMAL=2'd0, `STATE_ATTENTION=2'd1, `STATE_EMERGENCY=2'd2, `STATE_SILENCED=2'd3 (constants.h)
- secs_left  out  8  remaining seconds in ATTENTION/SILENCED; 0 otherwise
- alarm_count  out  8  number of EMERGENCY entries, saturating

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=NORMAL, secs_left=0, alarm_count=0, prescaler=0, ack_q=1.
  - ack_q=1 means an ack held high through reset gives no edge.
- Ack edge: ack_rise = ack & ~ack_q; ack_q <= ack every cycle.
- Prescaler: counts 0..TICKS_PER_SEC-1.
  - sec_tick = (prescaler==TICKS_PER_SEC-1).
  - Cleared to 0 on every state transition, so each timed state lasts exactly secs*TICKS_PER_SEC cycles from the entry edge.
- All outputs are registered; a condition sampled at edge k is visible on `state` after edge k.
- NORMAL:
  - trigger=1 -> ATTENTION; secs_left<=ATTENTION_SECS.
- ATTENTION:
  - ack_rise -> SILENCED; secs_left<=SILENCE_SECS.
  - Else sec_tick with secs_left==1 -> EMERGENCY; secs_left<=0; alarm_count+=1 (holds at 255).
  - Else sec_tick -> secs_left-=1.
  - Ack has priority over timeout on the same cycle.
  - Trigger deassertion does not leave ATTENTION (see optional feature).
- EMERGENCY:
  - ack_rise with trigger=0 -> NORMAL.
  - ack_rise with trigger=1 is ignored; the state holds.
  - No timeout.
- SILENCED:
  - trigger and ack are ignored until expiry.
  - sec_tick with secs_left==1 -> ATTENTION (secs_left<=ATTENTION_SECS) if trigger=1, else NORMAL (secs_left<=0).
  - Else sec_tick -> secs_left-=1.
- secs_left never underflows; it is 0 in NORMAL and EMERGENCY.
- rst asserted mid-countdown forces all reset values on the next edge; alarm_count is also cleared.

Optional Feature:
- Macro: ALARM_AUTO_CLEAR_EN.
- Defined:
  - In ATTENTION, an 8-bit clear counter increments on each sec_tick while trigger=0.
  - It resets to 0 on any cycle with trigger=1 and on ATTENTION entry.
  - Reaching CLEAR_SECS -> NORMAL; secs_left<=0.
  - Priority: ack > timeout escalation > auto-clear.
  - secs_left behaviour is unchanged.
- Undefined: no clear counter exists; ATTENTION latches until ack or escalation.

Test Plan (TICKS_PER_SEC=4, ATTENTION_SECS=3, SILENCE_SECS=2, CLEAR_SECS=2):
- Escalation: trigger=1 at edge 0 -> state=1 after edge 0, secs_left=3; secs_left steps 2 at edge 4, 1 at edge 8; state=2 after edge 12, secs_left=0, alarm_count=1.
- Ack then re-arm: ack pulse at edge 5 in ATTENTION -> state=3, secs_left=2; trigger held 1 -> state=1 after edge 13, secs_left=3. Same run with trigger=0 at expiry -> state=0.
- Emergency clear rules:
  - In EMERGENCY, ack with trigger=1 -> stays 2.
  - Drop trigger, ack -> state=0 next edge.
  - Ack held high across rst release -> no transition.
- Ack/timeout collision: ack rising edge on the same edge as the final sec_tick in ATTENTION -> state=3; alarm_count unchanged.
- Saturation and reset:
  - Force 256 escalations -> alarm_count=255.
  - rst mid-ATTENTION (secs_left=2) -> state=0, secs_left=0, alarm_count=0 after the reset edge.
- ALARM_AUTO_CLEAR_EN:
  - Enter ATTENTION, trigger=0 from edge 1 -> state=0 after 2 sec_ticks (edge 8).
  - Glitch trigger=1 for one cycle at edge 6 -> clear counter restarts and the alarm escalates at edge 12 instead.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: NORMAL -> ATTENTION -> EMERGENCY escalation with timed SILENCED period.
// Optional ATTENTION auto-clear is compiled in with `define ALARM_AUTO_CLEAR_EN.
module alarm_ctrl #(
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int ATTENTION_SECS = 10,
    parameter int SILENCE_SECS   = 30,
    parameter int CLEAR_SECS     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       ack,
    output logic [1:0] state,
    output logic [7:0] secs_left,
    output logic [7:0] alarm_count
);

    localparam int             PW          = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]  TICK_MAX    = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]     ATTN_LOAD   = 8'(ATTENTION_SECS);
    localparam logic [7:0]     SILENCE_LOAD = 8'(SILENCE_SECS);

    if (TICKS_PER_SEC < 2 || ATTENTION_SECS < 1 || ATTENTION_SECS > 255 ||
        SILENCE_SECS < 1 || SILENCE_SECS > 255 || CLEAR_SECS < 1 || CLEAR_SECS > 255) begin : g_bad_param
        $error("alarm_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_ATTENTION = 2'd1,
        ST_EMERGENCY = 2'd2,
        ST_SILENCED  = 2'd3
    } state_t;

    state_t        cur;
    logic [PW-1:0] prescaler;
    logic          ack_q;
    logic          sec_tick;
    logic          ack_rise;

    assign sec_tick = (prescaler == TICK_MAX);
    assign ack_rise = ack & ~ack_q;
    assign state    = cur;

`ifdef ALARM_AUTO_CLEAR_EN
    localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_SECS - 1);
    logic [7:0] clear_cnt;
    logic       auto_clear;

    // Trigger-low seconds only count in ATTENTION; any trigger-high cycle restarts them.
    assign auto_clear = sec_tick && !trigger && (clear_cnt == CLEAR_LAST);

    always_ff @(posedge clk) begin
        if (rst || cur != ST_ATTENTION || trigger) begin
            clear_cnt <= '0;
        end else if (sec_tick) begin
            clear_cnt <= clear_cnt + 8'd1;
        end
    end
`else
    logic auto_clear;
    assign auto_clear = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all next-state terms
    // read the pre-edge values; later assignments in the block deliberately override earlier defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= ST_NORMAL;
            secs_left   <= '0;
            alarm_count <= '0;
            prescaler   <= '0;
            ack_q       <= 1'b1;
        end else begin
            ack_q     <= ack;
            prescaler <= sec_tick ? '0 : prescaler + PW'(1);

            unique case (cur)
                ST_NORMAL: begin
                    if (trigger) begin
                        cur       <= ST_ATTENTION;
                        secs_left <= ATTN_LOAD;
                        prescaler <= '0;
                    end
                end

                ST_ATTENTION: begin
                    if (ack_rise) begin
                        cur       <= ST_SILENCED;
                        secs_left <= SILENCE_LOAD;
                        prescaler <= '0;
                    end else if (sec_tick && secs_left == 8'd1) begin
                        cur       <= ST_EMERGENCY;
                        secs_left <= '0;
                        prescaler <= '0;
                        if (alarm_count != 8'hFF) begin
                            alarm_count <= alarm_count + 8'd1;
                        end
                    end else if (auto_clear) begin
                        cur       <= ST_NORMAL;
                        secs_left <= '0;
                        prescaler <= '0;
                    end else if (sec_tick && secs_left != 8'd0) begin
                        secs_left <= secs_left - 8'd1;
                    end
                end

                ST_EMERGENCY: begin
                    if (ack_rise && !trigger) begin
                        cur       <= ST_NORMAL;
                        prescaler <= '0;
                    end
                end

                ST_SILENCED: begin
                    if (sec_tick && secs_left == 8'd1) begin
                        prescaler <= '0;
                        if (trigger) begin
                            cur       <= ST_ATTENTION;
                            secs_left <= ATTN_LOAD;
                        end else begin
                            cur       <= ST_NORMAL;
                            secs_left <= '0;
                        end
                    end else if (sec_tick && secs_left != 8'd0) begin
                        secs_left <= secs_left - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl with 4-cycle seconds; expectations queued per stimulus step.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger;
    logic       ack;
    logic [1:0] state;
    logic [7:0] secs_left;
    logic [7:0] alarm_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [7:0] secs;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alarm_ctrl #(
        .TICKS_PER_SEC (4),
        .ATTENTION_SECS(3),
        .SILENCE_SECS  (2),
        .CLEAR_SECS    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .ack        (ack),
        .state      (state),
        .secs_left  (secs_left),
        .alarm_count(alarm_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Advance n clock edges; outputs are sampled 1 time unit after each edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st,
                              input logic [7:0] secs, input logic [7:0] cnt);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.secs = secs;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, ".state"},       32'(state),       32'(e.st));
            check({e.tag, ".secs_left"},   32'(secs_left),   32'(e.secs));
            check({e.tag, ".alarm_count"}, 32'(alarm_count), 32'(e.cnt));
        end
    endtask

    // Queue the expectation, run n edges, then compare against the DUT.
    task automatic go(input int n, input string tag, input logic [1:0] st,
                      input logic [7:0] secs, input logic [7:0] cnt);
        expect_out(tag, st, secs, cnt);
        step(n);
        compare_out();
    endtask

    // Leaves rst low at posedge+1; the next edge is "edge 0".
    task automatic do_reset(input logic ack_val);
        rst     = 1'b1;
        trigger = 1'b0;
        ack     = ack_val;
        go(2, "reset", 2'd0, 8'd0, 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        trigger = 1'b0;
        ack     = 1'b0;

        // Escalation to EMERGENCY, then emergency clear rules.
        do_reset(1'b0);
        trigger = 1'b1;
        go(1, "esc_e0",  2'd1, 8'd3, 8'd0);
        go(3, "esc_e3",  2'd1, 8'd3, 8'd0);
        go(1, "esc_e4",  2'd1, 8'd2, 8'd0);
        go(4, "esc_e8",  2'd1, 8'd1, 8'd0);
        go(3, "esc_e11", 2'd1, 8'd1, 8'd0);
        go(1, "esc_e12", 2'd2, 8'd0, 8'd1);
        go(4, "emerg_no_timeout", 2'd2, 8'd0, 8'd1);
        ack = 1'b1;
        go(1, "emerg_ack_trig", 2'd2, 8'd0, 8'd1);
        ack = 1'b0;
        trigger = 1'b0;
        go(1, "emerg_drop", 2'd2, 8'd0, 8'd1);
        ack = 1'b1;
        go(1, "emerg_clear", 2'd0, 8'd0, 8'd1);
        ack = 1'b0;

        // Ack held high through reset release gives no edge.
        do_reset(1'b1);
        trigger = 1'b1;
        go(1, "ackrst_e0",   2'd1, 8'd3, 8'd0);
        go(3, "ackrst_hold", 2'd1, 8'd3, 8'd0);
        ack = 1'b0;
        trigger = 1'b0;

        // Ack, silence, re-arm with trigger still high.
        do_reset(1'b0);
        trigger = 1'b1;
        go(5, "rearm_e4", 2'd1, 8'd2, 8'd0);
        ack = 1'b1;
        go(1, "rearm_e5", 2'd3, 8'd2, 8'd0);
        ack = 1'b0;
        go(4, "rearm_e9",  2'd3, 8'd1, 8'd0);
        go(3, "rearm_e12", 2'd3, 8'd1, 8'd0);
        go(1, "rearm_e13", 2'd1, 8'd3, 8'd0);

        // Same run, trigger low at expiry; inputs ignored while silenced.
        do_reset(1'b0);
        trigger = 1'b1;
        step(5);
        ack = 1'b1;
        go(1, "sil_e5", 2'd3, 8'd2, 8'd0);
        ack = 1'b0;
        trigger = 1'b0;
        step(1);
        ack = 1'b1;
        trigger = 1'b1;
        go(1, "sil_ignore_e7", 2'd3, 8'd2, 8'd0);
        ack = 1'b0;
        trigger = 1'b0;
        go(6, "sil_expire_e13", 2'd0, 8'd0, 8'd0);

        // Ack rising on the same edge as the final ATTENTION tick wins.
        do_reset(1'b0);
        trigger = 1'b1;
        go(12, "coll_e11", 2'd1, 8'd1, 8'd0);
        ack = 1'b1;
        go(1, "coll_e12", 2'd3, 8'd2, 8'd0);
        ack = 1'b0;
        trigger = 1'b0;

`ifdef ALARM_AUTO_CLEAR_EN
        do_reset(1'b0);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        go(7, "aclr_e7", 2'd1, 8'd2, 8'd0);
        go(1, "aclr_e8", 2'd0, 8'd0, 8'd0);

        do_reset(1'b0);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(5);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        go(2, "glitch_e8",  2'd1, 8'd1, 8'd0);
        go(4, "glitch_e12", 2'd2, 8'd0, 8'd1);
`else
        // Without auto-clear, ATTENTION latches after trigger drops.
        do_reset(1'b0);
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        go(8, "latch_e8",  2'd1, 8'd1, 8'd0);
        go(4, "latch_e12", 2'd2, 8'd0, 8'd1);
`endif

        // 256 escalations saturate alarm_count at 255.
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) begin
            trigger = 1'b1;
            if (i == 0 || i >= 254) begin
                go(13, "sat_emerg", 2'd2, 8'd0, (i >= 255) ? 8'd255 : 8'(i + 1));
            end else begin
                step(13);
            end
            trigger = 1'b0;
            ack = 1'b1;
            step(1);
            ack = 1'b0;
            step(1);
        end
        go(1, "sat_final", 2'd0, 8'd0, 8'd255);

        // Reset mid-ATTENTION clears everything including alarm_count.
        trigger = 1'b1;
        go(5, "rstmid_e4", 2'd1, 8'd2, 8'd255);
        rst = 1'b1;
        go(1, "rstmid", 2'd0, 8'd0, 8'd0);
        rst = 1'b0;
        trigger = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
